// File: rtl/window_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | window_pkg : shared pixel type, channel indices and FSM states   |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
package window_pkg;

  localparam int COLOR_CHANNEL_DEF = 8;

  typedef logic [2:0][COLOR_CHANNEL_DEF-1:0] pixel_t;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_buffer : one image line of pixels, registered read port     |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH         = 640,
  parameter int COLOR_CHANNEL = 8,
  parameter int AW            = $clog2(DEPTH)
) (
  input  logic                          i_clk,
  input  logic                          i_en,
  input  logic [AW-1:0]                 i_wr_addr,
  input  logic [AW-1:0]                 i_rd_addr,
  input  logic [2:0][COLOR_CHANNEL-1:0] i_data,
  output logic [2:0][COLOR_CHANNEL-1:0] o_data
);

  logic [2:0][COLOR_CHANNEL-1:0] mem_q [DEPTH];
  logic [2:0][COLOR_CHANNEL-1:0] rd_q;

  // Read is issued one pixel ahead so the word for x is already on o_data
  // when pixel x arrives; old data is returned if the addresses coincide.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      rd_q              <= mem_q[i_rd_addr];
      mem_q[i_wr_addr]  <= i_data;
    end
  end

  assign o_data = rd_q;

endmodule
`default_nettype wire

// File: rtl/window_generator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | window_generator : KERNELxKERNEL RGB window from a raster stream |
// | Option WINDOW_COORD_EN adds o_x/o_y (window centre coordinates)  |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module window_generator
  import window_pkg::*;
#(
  parameter int KERNEL        = 3,
  parameter int COLOR_CHANNEL = 8,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_valid,
  input  logic                                     i_sof,
  input  logic [2:0][COLOR_CHANNEL-1:0]            i_pixel,
  output logic                                     o_valid,
  output logic                                     o_eof,
  output logic [KERNEL-1:0][2:0][COLOR_CHANNEL-1:0] o_pixel_area_data [KERNEL-1:0]
`ifdef WINDOW_COORD_EN
  ,
  output logic [$clog2(IMAGE_WIDTH)-1:0]           o_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]          o_y
`endif
);

  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(KERNEL - 1);
  localparam logic [YW-1:0] Y_WIN  = YW'(KERNEL - 1);

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d, cur_x, next_x;
  logic [YW-1:0]     y_q, y_d, cur_y;
  logic              accept, emit, line_end, frame_end;
  logic              valid_q, eof_q;

  logic [2:0][COLOR_CHANNEL-1:0] lb_din  [KERNEL-1];
  logic [2:0][COLOR_CHANNEL-1:0] lb_dout [KERNEL-1];
  logic [2:0][COLOR_CHANNEL-1:0] col     [KERNEL];
  logic [KERNEL-1:0][2:0][COLOR_CHANNEL-1:0] win_q [KERNEL-1:0];

  // A start-of-frame pixel is always (0,0), whatever the counters held.
  always_comb begin
    accept    = i_valid && (i_sof || (state_q != S_IDLE));
    cur_x     = i_sof ? '0 : x_q;
    cur_y     = i_sof ? '0 : y_q;
    line_end  = (cur_x == X_LAST);
    frame_end = line_end && (cur_y == Y_LAST);
    next_x    = line_end ? '0 : cur_x + XW'(1);
    emit      = accept && (cur_x >= X_WIN) && (cur_y >= Y_WIN);
    x_d       = x_q;
    y_d       = y_q;
    state_d   = state_q;
    if (accept) begin
      x_d = next_x;
      if (line_end) y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      else          y_d = cur_y;
      if (frame_end)       state_d = S_IDLE;
      else if (y_d >= Y_WIN) state_d = S_RUN;
      else                 state_d = S_FILL;
    end
  end

  for (genvar k = 0; k < KERNEL - 1; k++) begin : g_line_buf
    if (k == 0) begin : g_head
      assign lb_din[k] = i_pixel;
    end else begin : g_tail
      assign lb_din[k] = lb_dout[k-1];
    end
    line_buffer #(
      .DEPTH         (IMAGE_WIDTH),
      .COLOR_CHANNEL (COLOR_CHANNEL),
      .AW            (XW)
    ) u_line_buffer (
      .i_clk     (i_clk),
      .i_en      (accept),
      .i_wr_addr (cur_x),
      .i_rd_addr (next_x),
      .i_data    (lb_din[k]),
      .o_data    (lb_dout[k])
    );
  end

  // Oldest line at the top of the incoming column, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < KERNEL - 1; r++) col[r] = lb_dout[KERNEL-2-r];
    col[KERNEL-1] = i_pixel;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      for (int r = 0; r < KERNEL; r++) win_q[r] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= emit;
      eof_q   <= emit && frame_end;
      if (accept) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL - 1; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][KERNEL-1] <= col[r];
        end
      end
    end
  end

  assign o_valid           = valid_q;
  assign o_eof             = eof_q;
  assign o_pixel_area_data = win_q;

`ifdef WINDOW_COORD_EN
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (emit) begin
      ox_q <= cur_x - XW'(KERNEL / 2);
      oy_q <= cur_y - YW'(KERNEL / 2);
    end
  end

  assign o_x = ox_q;
  assign o_y = oy_q;
`endif

endmodule
`default_nettype wire
